rf_writeback: RTL and testbench

Write-back unit that is the sole writer of the 4 × 8-bit register file. It merges results from two producers into the file's single write port (wb, data, reg_en):
- the single-cycle ALU, which has no queue;
- the load path, which has a valid/ready handshake and a 2-entry buffer.

It keeps write ordering correct, back-pressures the producers when required, and publishes a pending-write mask for the hazard logic. Outputs are registered on posedge clk so they are stable for the register file's negedge capture.

---
 rtl/rf_pkg.sv | 22 ++
 rtl/rf_writeback_wb_fifo.sv | 87 ++++++++
 rtl/rf_writeback.sv | 105 ++++++++++
 tb/tb_rf_writeback.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared types and helpers for the register-file write-back slice.
package rf_pkg;

  localparam int NUM_REGS   = 4;
  localparam int REG_ADDR_W = 2;
  localparam int DATA_W     = 8;

  // One pending register-file write: destination and payload.
  typedef struct packed {
    logic [REG_ADDR_W-1:0]    wb;
    logic signed [DATA_W-1:0] data;
  } wb_entry_t;

  // Register address to a one-hot register mask.
  function automatic logic [NUM_REGS-1:0] onehot(input logic [REG_ADDR_W-1:0] addr);
    logic [NUM_REGS-1:0] v;
    v       = '0;
    v[addr] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rf_writeback_wb_fifo.sv
// Load buffer kept compacted toward entry 0 (the head).
// Each edge it can pop the head, append a new load, and drop every entry
// (including the one being appended) whose destination matches sq_wb.
module wb_fifo
  import rf_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 2)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             push,
  input  wb_entry_t                        push_ent,
  input  logic                             pop,
  input  logic                             sq_en,
  input  logic [REG_ADDR_W-1:0]            sq_wb,
  output wb_entry_t                        head,
  output logic                             full,
  output logic                             empty,
  output logic [DEPTH-1:0]                 vld,
  output logic [DEPTH-1:0][REG_ADDR_W-1:0] ent_wb,
  output logic [CNT_W-1:0]                 removed
);

  wb_entry_t        ent_q [DEPTH];
  logic [DEPTH-1:0] vld_q;
  wb_entry_t        ent_d [DEPTH];
  logic [DEPTH-1:0] vld_d;
  wb_entry_t        cand  [DEPTH+1];
  logic [DEPTH:0]   keep;
  logic             placed;

  // Survivors in age order: remaining entries after the pop, then the new load.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      cand[i] = ent_q[i];
      keep[i] = vld_q[i] && !(pop && (i == 0));
    end
    cand[DEPTH] = push_ent;
    keep[DEPTH] = push;
  end

  // Filter out squashed survivors and pack the rest toward the head.
  always_comb begin
    vld_d   = '0;
    removed = '0;
    placed  = 1'b0;
    for (int j = 0; j < DEPTH; j++) ent_d[j] = ent_q[j];
    for (int i = 0; i <= DEPTH; i++) begin
      placed = 1'b0;
      if (keep[i]) begin
        if (sq_en && (cand[i].wb == sq_wb)) begin
          removed = removed + CNT_W'(1);
        end else begin
          for (int j = 0; j < DEPTH; j++) begin
            if (!placed && !vld_d[j]) begin
              ent_d[j] = cand[i];
              vld_d[j] = 1'b1;
              placed   = 1'b1;
            end
          end
        end
      end
    end
  end

  // Occupancy is cleared asynchronously; buffered writes are discarded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) vld_q <= '0;
    else     vld_q <= vld_d;
  end

  // Entry payloads need no reset: they are only observed through vld_q.
  always_ff @(posedge clk) begin
    for (int j = 0; j < DEPTH; j++) ent_q[j] <= ent_d[j];
  end

  // Status and per-entry destinations for the hazard mask.
  always_comb begin
    head  = ent_q[0];
    full  = vld_q[DEPTH-1];
    empty = !vld_q[0];
    vld   = vld_q;
    for (int j = 0; j < DEPTH; j++) ent_wb[j] = ent_q[j].wb;
  end

endmodule

// File: rtl/rf_writeback.sv
// Sole writer of the 4 x 8-bit register file. Merges the single-cycle ALU
// with the buffered load path, keeps write order, squashes stale loads
// overtaken by a younger ALU write, and publishes the pending-write mask.
module rf_writeback
  import rf_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alu_valid,
  input  logic [REG_ADDR_W-1:0]    alu_wb,
  input  logic signed [DATA_W-1:0] alu_data,
  output logic                     alu_stall,
  input  logic                     ld_valid,
  output logic                     ld_ready,
  input  logic [REG_ADDR_W-1:0]    ld_wb,
  input  logic signed [DATA_W-1:0] ld_data,
  output logic [REG_ADDR_W-1:0]    wb,
  output logic signed [DATA_W-1:0] data,
  output logic                     reg_en,
  output logic [NUM_REGS-1:0]      pending,
  output logic [7:0]               squash_cnt
);

  localparam int CNT_W = $clog2(DEPTH + 2);

  logic                             push;
  logic                             pop;
  logic                             take_alu;
  wb_entry_t                        ld_ent;
  wb_entry_t                        head;
  logic                             fifo_full;
  logic                             fifo_empty;
  logic [DEPTH-1:0]                 fifo_vld;
  logic [DEPTH-1:0][REG_ADDR_W-1:0] fifo_ent_wb;
  logic [CNT_W-1:0]                 removed;

  function automatic logic [7:0] sat_add(input logic [7:0] acc, input logic [CNT_W-1:0] inc);
    logic [8:0] sum;
    sum = {1'b0, acc} + 9'(inc);
    return sum[8] ? 8'hFF : sum[7:0];
  endfunction

  // Selection: a full buffer forces its head out ahead of the ALU, which then
  // stalls; otherwise the ALU wins; otherwise the buffer drains. Readiness and
  // stall look only at registered occupancy, never at ld_valid.
  always_comb begin
    alu_stall   = alu_valid && fifo_full;
    ld_ready    = !fifo_full && !rst;
    push        = ld_valid && ld_ready;
    take_alu    = alu_valid && !fifo_full;
    pop         = !take_alu && !fifo_empty;
    ld_ent.wb   = ld_wb;
    ld_ent.data = ld_data;
  end

  wb_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_ent (ld_ent),
    .pop      (pop),
    .sq_en    (take_alu),
    .sq_wb    (alu_wb),
    .head     (head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .vld      (fifo_vld),
    .ent_wb   (fifo_ent_wb),
    .removed  (removed)
  );

  // Registered write port and squash counter; address/data hold when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb         <= '0;
      data       <= '0;
      reg_en     <= 1'b0;
      squash_cnt <= '0;
    end else begin
      reg_en     <= take_alu || pop;
      squash_cnt <= sat_add(squash_cnt, removed);
      if (take_alu) begin
        wb   <= alu_wb;
        data <= alu_data;
      end else if (pop) begin
        wb   <= head.wb;
        data <= head.data;
      end
    end
  end

  // Hazard mask from registered state only: buffered loads plus the write in flight.
  always_comb begin
    pending = reg_en ? onehot(wb) : '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (fifo_vld[i]) pending = pending | onehot(fifo_ent_wb[i]);
    end
  end

endmodule

// File: tb/tb_rf_writeback.sv
// Bench for rf_writeback: directed scenarios with literal expectations plus a
// randomized phase, all checked every cycle against a queue-based model.
module tb_rf_writeback;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       alu_valid, ld_valid;
  logic [1:0] alu_wb, ld_wb;
  logic [7:0] alu_data, ld_data;
  logic       alu_stall, ld_ready, reg_en;
  logic [1:0] wb;
  logic [7:0] data;
  logic [3:0] pending;
  logic [7:0] squash_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rf_writeback dut (
    .clk        (clk),
    .rst        (rst),
    .alu_valid  (alu_valid),
    .alu_wb     (alu_wb),
    .alu_data   (alu_data),
    .alu_stall  (alu_stall),
    .ld_valid   (ld_valid),
    .ld_ready   (ld_ready),
    .ld_wb      (ld_wb),
    .ld_data    (ld_data),
    .wb         (wb),
    .data       (data),
    .reg_en     (reg_en),
    .pending    (pending),
    .squash_cnt (squash_cnt)
  );

  typedef struct {
    logic [1:0] wb;
    logic [7:0] d;
  } ent_t;

  // Reference model: load buffer as a queue in age order, plus the write port.
  ent_t       q[$];
  logic       m_en  = 1'b0;
  logic [1:0] m_wb  = 2'd0;
  logic [7:0] m_d   = 8'd0;
  int         m_cnt = 0;

  logic       c_av, c_lv;
  logic [1:0] c_awb, c_lwb;
  logic [7:0] c_ad, c_ld;
  logic       c_rst;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] m_pending();
    logic [3:0] p;
    p = m_en ? (4'b0001 << m_wb) : 4'b0000;
    foreach (q[i]) p = p | (4'b0001 << q[i].wb);
    return p;
  endfunction

  task automatic model_reset();
    q.delete();
    m_en  = 1'b0;
    m_wb  = 2'd0;
    m_d   = 8'd0;
    m_cnt = 0;
  endtask

  task automatic model_step();
    bit   push;
    int   n;
    ent_t e;
    push = c_lv && (q.size() < 2);
    if (c_av && q.size() == 2) begin
      e    = q.pop_front();
      m_en = 1'b1; m_wb = e.wb; m_d = e.d;
    end else if (c_av) begin
      if (push) q.push_back('{c_lwb, c_ld});
      n = 0;
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (q[i].wb == c_awb) begin
          q.delete(i);
          n++;
        end
      end
      m_cnt = (m_cnt + n > 255) ? 255 : m_cnt + n;
      m_en = 1'b1; m_wb = c_awb; m_d = c_ad;
    end else if (q.size() > 0) begin
      e    = q.pop_front();
      m_en = 1'b1; m_wb = e.wb; m_d = e.d;
      if (push) q.push_back('{c_lwb, c_ld});
    end else begin
      m_en = 1'b0;
      if (push) q.push_back('{c_lwb, c_ld});
    end
  endtask

  task automatic check_regs(input string tag);
    chk({tag, "_reg_en"}, reg_en, m_en);
    chk({tag, "_wb"}, wb, m_wb);
    chk({tag, "_data"}, data, m_d);
    chk({tag, "_pending"}, pending, m_pending());
    chk({tag, "_squash_cnt"}, squash_cnt, m_cnt[7:0]);
  endtask

  // Compare process: mid-cycle checks of handshake and held outputs, then the
  // post-edge check of the registered outputs after advancing the model.
  initial begin : cmp
    forever begin
      @(negedge clk); #2;
      c_rst = rst; c_av = alu_valid; c_awb = alu_wb; c_ad = alu_data;
      c_lv = ld_valid; c_lwb = ld_wb; c_ld = ld_data;
      if (rst) model_reset();
      chk("mdl_ld_ready", ld_ready, (!rst && q.size() < 2));
      chk("mdl_alu_stall", alu_stall, (alu_valid && q.size() == 2));
      check_regs("mdl_mid");
      @(posedge clk);
      if (!c_rst) model_step();
      #1;
      check_regs("mdl_edge");
    end
  end

  task automatic set_in(input logic av, input logic [1:0] awb, input logic [7:0] ad,
                        input logic lv, input logic [1:0] lwb, input logic [7:0] ld);
    alu_valid = av; alu_wb = awb; alu_data = ad;
    ld_valid  = lv; ld_wb  = lwb; ld_data  = ld;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin : drv
    logic [7:0] neg5;
    neg5 = -8'sd5;
    set_in(0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("ready_after_reset", ld_ready, 1);

    // ALU path
    @(negedge clk); set_in(1, 2, neg5, 0, 0, 0);
    @(posedge clk); #1;
    chk("alu_en", reg_en, 1); chk("alu_wb", wb, 2);
    chk("alu_data", data, 8'hFB); chk("alu_pending", pending, 4'b0100);
    @(negedge clk); set_in(0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    chk("alu_idle_en", reg_en, 0); chk("alu_idle_pending", pending, 4'b0000);

    // Load fill and drain
    @(negedge clk); set_in(0, 0, 0, 1, 1, 8'd10);
    @(posedge clk); #1;
    chk("ld1_en", reg_en, 0); chk("ld1_pending", pending, 4'b0010);
    @(negedge clk); set_in(0, 0, 0, 1, 3, 8'd20);
    @(posedge clk); #1;
    chk("ld_w1_en", reg_en, 1); chk("ld_w1_wb", wb, 1); chk("ld_w1_data", data, 8'd10);
    chk("ld_w1_pending", pending, 4'b1010);
    @(negedge clk); set_in(0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    chk("ld_w2_wb", wb, 3); chk("ld_w2_data", data, 8'd20); chk("ld_w2_pending", pending, 4'b1000);
    @(posedge clk); #1;
    chk("ld_done_en", reg_en, 0); chk("ld_done_pending", pending, 4'b0000);

    // Full and stall
    @(negedge clk); set_in(1, 2, 8'd1, 1, 0, 8'd40);
    @(negedge clk); set_in(1, 2, 8'd2, 1, 1, 8'd41);
    @(negedge clk); set_in(1, 3, 8'd33, 0, 0, 0); #1;
    chk("full_stall", alu_stall, 1); chk("full_ready", ld_ready, 0);
    @(posedge clk); #1;
    chk("full_head_en", reg_en, 1); chk("full_head_wb", wb, 0); chk("full_head_data", data, 8'd40);
    @(negedge clk); #1;
    chk("after_stall", alu_stall, 0); chk("after_ready", ld_ready, 1);
    @(posedge clk); #1;
    chk("stalled_alu_wb", wb, 3); chk("stalled_alu_data", data, 8'd33);
    @(negedge clk); set_in(0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    chk("drain_wb", wb, 1); chk("drain_data", data, 8'd41);

    // Squash of a stale load overtaken by the ALU
    @(negedge clk); set_in(1, 0, 8'd5, 1, 2, 8'd50);
    @(negedge clk); set_in(1, 2, 8'd7, 1, 1, 8'd60);
    @(posedge clk); #1;
    chk("sq_wb", wb, 2); chk("sq_data", data, 8'd7); chk("sq_cnt", squash_cnt, 1);
    chk("sq_pending", pending, 4'b0110);
    @(negedge clk); set_in(0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    chk("sq_left_wb", wb, 1); chk("sq_left_data", data, 8'd60);
    @(posedge clk); #1;
    chk("sq_idle_en", reg_en, 0);

    // Reset with two loads buffered
    @(negedge clk); set_in(1, 3, 8'd9, 1, 0, 8'd70);
    @(negedge clk); set_in(1, 3, 8'd9, 1, 1, 8'd71);
    @(negedge clk); set_in(1, 3, 8'd9, 1, 2, 8'd72); rst = 1'b1; #1;
    chk("rst_en", reg_en, 0); chk("rst_wb", wb, 0); chk("rst_data", data, 0);
    chk("rst_pending", pending, 0); chk("rst_cnt", squash_cnt, 0);
    chk("rst_ready", ld_ready, 0); chk("rst_stall", alu_stall, 0);
    @(posedge clk); #1;
    chk("rst_edge_en", reg_en, 0);
    @(negedge clk); rst = 1'b0; set_in(0, 0, 0, 0, 0, 0); #1;
    chk("rst_rel_ready", ld_ready, 1); chk("rst_rel_pending", pending, 0);
    @(posedge clk); #1;
    chk("rst_rel_en", reg_en, 0);

    // Saturation: one squash per cycle, 300 times
    for (int k = 0; k < 300; k++) begin
      @(negedge clk); set_in(1, k[1:0], k[7:0], 1, k[1:0], 8'hAA);
    end
    @(posedge clk); #1;
    chk("sat_cnt", squash_cnt, 255);
    @(negedge clk); set_in(0, 0, 0, 0, 0, 0);

    // Randomized traffic with occasional resets
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 199) == 0);
      set_in(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 8'($urandom),
             ($urandom_range(0, 9) < 6), 2'($urandom_range(0, 3)), 8'($urandom));
    end
    @(negedge clk); rst = 1'b0; set_in(0, 0, 0, 0, 0, 0);
    repeat (4) @(posedge clk);
    #3;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
